// File: rtl/ro_meter_pkg.sv
// rtl/ro_meter_pkg.sv - shared types and defaults for the ring-oscillator readers
package ro_meter_pkg;
  typedef enum logic [1:0] {IDLE, SETTLE, COUNT, DONE} state_e;

  localparam int SYNC_STAGES_DEF = 2;
  localparam int CNT_W_DEF       = 16;
  localparam int WIN_W_DEF       = 16;
endpackage

// File: rtl/ro_freq_meter_if.sv
// rtl/ro_freq_meter_if.sv - control/result bundle of the ring-oscillator frequency meter
interface ro_freq_meter_if
  import ro_meter_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int WIN_W = WIN_W_DEF
);
  logic             start;
  logic             abort;
  logic [WIN_W-1:0] win_len;
  logic             busy;
  logic             valid;
  logic [CNT_W-1:0] count;
  logic             ovf;

  modport master (output start, abort, win_len, input busy, valid, count, ovf);
  modport slave  (input start, abort, win_len, output busy, valid, count, ovf);
endinterface

// File: rtl/ro_sync_edge.sv
// rtl/ro_sync_edge.sv - synchroniser plus history flop, one-cycle pulse per rising edge
module ro_sync_edge
  import ro_meter_pkg::*;
#(
  parameter int STAGES = SYNC_STAGES_DEF
) (
  input  logic ck,
  input  logic rst,
  input  logic d_i,
  output logic edge_o
);
  logic [STAGES-1:0] sync_q, sync_d;
  logic              hist_q, hist_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d_i};
    hist_d = sync_q[STAGES-1];
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
    end
  end

  assign edge_o = sync_q[STAGES-1] & ~hist_q;
endmodule

// File: rtl/ro_freq_meter.sv
// rtl/ro_freq_meter.sv - counts synchronised oscillator rising edges over a window of ck cycles
module ro_freq_meter
  import ro_meter_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int WIN_W       = WIN_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic               ck,
  input  logic               rst,
  input  logic               ro_i,
  ro_freq_meter_if.slave     bus
);
  localparam int ST_W = $clog2(SYNC_STAGES + 1) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e           state_q, state_d;
  logic [WIN_W-1:0] win_r_q, win_r_d;
  logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
  logic [CNT_W-1:0] ecnt_q, ecnt_d;
  logic             eovf_q, eovf_d;
  logic [ST_W-1:0]  settle_q, settle_d;
  logic             busy_q, busy_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             ro_edge;

  ro_sync_edge #(.STAGES(SYNC_STAGES)) u_sync (
    .ck     (ck),
    .rst    (rst),
    .d_i    (ro_i),
    .edge_o (ro_edge)
  );

  always_comb begin
    state_d   = state_q;
    win_r_d   = win_r_q;
    win_cnt_d = win_cnt_q;
    ecnt_d    = ecnt_q;
    eovf_d    = eovf_q;
    settle_d  = settle_q;
    busy_d    = busy_q;
    valid_d   = valid_q;
    count_d   = count_q;
    ovf_d     = ovf_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.abort) begin
          state_d = IDLE;
          valid_d = 1'b0;
        end else if (bus.start) begin
          win_r_d = bus.win_len;
          if (bus.win_len == '0) begin
            state_d = DONE;
            valid_d = 1'b1;
            count_d = '0;
            ovf_d   = 1'b0;
          end else begin
            state_d  = SETTLE;
            busy_d   = 1'b1;
            valid_d  = 1'b0;
            settle_d = '0;
          end
        end
      end
      SETTLE: begin
        if (bus.abort) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          // Edges seen here come from stale synchroniser contents
          ecnt_d    = '0;
          eovf_d    = 1'b0;
          win_cnt_d = win_r_q;
          if (settle_q == ST_W'(SYNC_STAGES)) state_d = COUNT;
          else settle_d = settle_q + ST_W'(1);
        end
      end
      COUNT: begin
        if (bus.abort) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          win_cnt_d = win_cnt_q - WIN_W'(1);
          if (ro_edge) begin
            if (ecnt_q == CNT_MAX) eovf_d = 1'b1;
            else ecnt_d = ecnt_q + CNT_W'(1);
          end
          if (win_cnt_q == WIN_W'(1)) begin
            state_d = DONE;
            busy_d  = 1'b0;
            valid_d = 1'b1;
            count_d = ecnt_d;
            ovf_d   = eovf_d;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      state_q   <= IDLE;
      win_r_q   <= '0;
      win_cnt_q <= '0;
      ecnt_q    <= '0;
      eovf_q    <= 1'b0;
      settle_q  <= '0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      win_r_q   <= win_r_d;
      win_cnt_q <= win_cnt_d;
      ecnt_q    <= ecnt_d;
      eovf_q    <= eovf_d;
      settle_q  <= settle_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
    end
  end

  assign bus.busy  = busy_q;
  assign bus.valid = valid_q;
  assign bus.count = count_q;
  assign bus.ovf   = ovf_q;
endmodule

// File: tb/tb_ro_freq_meter.sv
// tb/tb_ro_freq_meter.sv - directed self-checking bench for ro_freq_meter
module tb_ro_freq_meter;
  logic       ck = 1'b0;
  logic       rst;
  logic [7:0] ro_div = '0;
  logic       ro8, ro4;
  int         n_checks = 0;
  int         n_err = 0;

  logic        busy_log  [0:255];
  logic        valid_log [0:255];
  logic [15:0] count_log [0:255];
  int nb, fv, nv;

  always #5 ck = ~ck;
  always @(negedge ck) ro_div <= ro_div + 8'd1;
  assign ro8 = ro_div[2];
  assign ro4 = ro_div[1];

  ro_freq_meter_if #(.CNT_W(16), .WIN_W(16)) a_if ();
  ro_freq_meter_if #(.CNT_W(4),  .WIN_W(16)) b_if ();

  ro_freq_meter #(.CNT_W(16), .WIN_W(16), .SYNC_STAGES(2)) dut_a (
    .ck(ck), .rst(rst), .ro_i(ro8), .bus(a_if.slave));
  ro_freq_meter #(.CNT_W(4), .WIN_W(16), .SYNC_STAGES(2)) dut_b (
    .ck(ck), .rst(rst), .ro_i(ro4), .bus(b_if.slave));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic start_a(input int w);
    a_if.win_len = 16'(w);
    a_if.start   = 1'b1;
    @(negedge ck);
    a_if.start   = 1'b0;
  endtask

  // Log cycles t+1..t+n after the accepted start; pulses are driven at chosen offsets
  task automatic watch_a(input int n, input int st1, input int st2, input int ab, input int rs);
    for (int i = 1; i <= n; i++) begin
      busy_log[i]  = a_if.busy;
      valid_log[i] = a_if.valid;
      count_log[i] = a_if.count;
      a_if.start   = (i == st1) || (i == st2) || (i == rs);
      a_if.abort   = (i == ab);
      rst          = (i == rs);
      @(negedge ck);
    end
    a_if.start = 1'b0;
    a_if.abort = 1'b0;
    rst        = 1'b0;
  endtask

  task automatic scan(input int n, output int nbusy, output int first_v, output int nvalid);
    nbusy = 0; first_v = 0; nvalid = 0;
    for (int i = 1; i <= n; i++) begin
      if (busy_log[i]) nbusy++;
      if (valid_log[i]) begin
        nvalid++;
        if (first_v == 0) first_v = i;
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    a_if.start = 1'b0; a_if.abort = 1'b0; a_if.win_len = '0;
    b_if.start = 1'b0; b_if.abort = 1'b0; b_if.win_len = '0;
    repeat (3) @(negedge ck);
    chk("rst_busy",  a_if.busy, 0);
    chk("rst_valid", a_if.valid, 0);
    chk("rst_count", a_if.count, 0);
    chk("rst_ovf",   a_if.ovf, 0);
    chk("rst_b_valid", b_if.valid, 0);
    rst = 1'b0;
    repeat (2) @(negedge ck);

    start_a(64);
    watch_a(75, 0, 0, 0, 0);
    scan(75, nb, fv, nv);
    chk("nom_busy_cycles", nb, 67);
    chk("nom_busy_last",   busy_log[67], 1);
    chk("nom_valid_at",    fv, 68);
    chk("nom_count",       a_if.count, 8);
    chk("nom_ovf",         a_if.ovf, 0);
    chk("nom_valid_held",  a_if.valid, 1);

    start_a(64);
    a_if.win_len = 16'd10;
    watch_a(75, 5, 20, 0, 0);
    scan(75, nb, fv, nv);
    chk("busy_restart_valid_clr", valid_log[1], 0);
    chk("busy_restart_valid_at",  fv, 68);
    chk("busy_restart_nvalid",    nv, 8);
    chk("busy_restart_count",     a_if.count, 8);

    a_if.abort = 1'b1;
    @(negedge ck);
    a_if.abort = 1'b0;
    chk("done_abort_valid", a_if.valid, 0);

    start_a(0);
    watch_a(5, 0, 0, 0, 0);
    scan(5, nb, fv, nv);
    chk("zero_valid_next", valid_log[1], 1);
    chk("zero_busy_never", nb, 0);
    chk("zero_count",      a_if.count, 0);
    chk("zero_ovf",        a_if.ovf, 0);

    start_a(64);
    watch_a(100, 0, 0, 30, 0);
    scan(100, nb, fv, nv);
    chk("abort_busy_before", busy_log[30], 1);
    chk("abort_busy_after",  busy_log[31], 0);
    chk("abort_no_valid",    nv, 0);
    start_a(32);
    watch_a(40, 0, 0, 0, 0);
    scan(40, nb, fv, nv);
    chk("after_abort_valid_at", fv, 36);
    chk("after_abort_count",    a_if.count, 4);

    start_a(64);
    watch_a(60, 0, 0, 0, 40);
    scan(60, nb, fv, nv);
    chk("srst_busy_cycles", nb, 40);
    chk("srst_busy_clr",    busy_log[41], 0);
    chk("srst_count_clr",   count_log[41], 0);
    chk("srst_no_valid",    nv, 0);
    chk("srst_ovf",         a_if.ovf, 0);
    start_a(64);
    watch_a(75, 0, 0, 0, 0);
    scan(75, nb, fv, nv);
    chk("post_rst_valid_at", fv, 68);
    chk("post_rst_count",    a_if.count, 8);

    b_if.win_len = 16'd100;
    b_if.start   = 1'b1;
    @(negedge ck);
    b_if.start   = 1'b0;
    fv = 0;
    for (int i = 1; i <= 120; i++) begin
      if (b_if.valid && fv == 0) fv = i;
      @(negedge ck);
    end
    chk("sat_valid_at", fv, 104);
    chk("sat_count",    b_if.count, 15);
    chk("sat_ovf",      b_if.ovf, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
